// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: rotate the request vector so the search
// starts just after the previous owner, take the lowest set bit, rotate back.
module rr_pick #(
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] start;
  logic [SUM_W-1:0] pos;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] enc;
  logic             found;
  logic [SUM_W-1:0] sum;

  always_comb begin
    start = (last == IDX_W'(NREQ - 1)) ? '0 : last + IDX_W'(1);
    pos   = '0;
    rot   = '0;
    // rot[i] is the requester i positions after the search start, with wrap
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, start} + SUM_W'(i);
      if (pos >= SUM_W'(NREQ)) begin
        pos = pos - SUM_W'(NREQ);
      end
      rot[i] = req[pos[IDX_W-1:0]];
    end

    enc   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rot[i] && !found) begin
        enc   = IDX_W'(i);
        found = 1'b1;
      end
    end

    sum = {1'b0, start} + {1'b0, enc};
    if (sum >= SUM_W'(NREQ)) begin
      sum = sum - SUM_W'(NREQ);
    end
    pick_idx = sum[IDX_W-1:0];
    pick_vld = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write channel among NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W     = $clog2(NREQ),
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_wr_data,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             owner_req;
  logic [WIDTH-1:0] owner_data;
  logic             xfer;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req      (req),
    .last     (last_q),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // Mux out the current owner's request and data slice.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    last_d       = last_q;
    gnt          = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    xfer         = (state_q == BURST) && owner_req && !fifo_full && !clr;

    if (clr) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      last_d     = IDX_W'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_d    = pick_idx;
            beat_cnt_d = '0;
            state_d    = BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            fifo_wr_en   = 1'b1;
            gnt          = NREQ'(1) << owner_q;
            fifo_wr_data = owner_data;
            beat_cnt_d   = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
              state_d = IDLE;
              last_d  = owner_q;
            end
          end else if (!owner_req) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
          // owner requesting against a full FIFO just holds here
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      last_q     <= IDX_W'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle check against a transaction-level
// model, plus literal per-cycle traces for each scenario.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic [1:0]            owner;
  logic                  busy;

  logic [7:0]  pdata [NREQ];
  int          checks   = 0;
  int          failures = 0;
  logic [13:0] trace [$];
  logic [13:0] expq  [$];

  // Abstract model: is a burst running, who owns it, beats taken, previous owner.
  bit m_burst = 1'b0;
  int m_owner = 0;
  int m_beats = 0;
  int m_last  = NREQ - 1;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = pdata[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_burst = 1'b0; m_owner = 0; m_beats = 0; m_last = NREQ - 1;
    end else if (clr) begin
      m_burst = 1'b0; m_beats = 0; m_last = NREQ - 1;
    end else if (!m_burst) begin
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (req[(m_last + k) % NREQ]) begin
            m_owner = (m_last + k) % NREQ;
            break;
          end
        end
        m_beats = 0;
        m_burst = 1'b1;
      end
    end else if (req[m_owner]) begin
      if (!fifo_full) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_burst = 1'b0; m_last = m_owner;
        end
      end
    end else begin
      m_burst = 1'b0; m_last = m_owner;
    end
  end

  // Per-cycle compare against the model and trace capture.
  always @(negedge clk) begin
    bit x;
    x = m_burst && req[m_owner] && !fifo_full && !clr;
    chk("gnt",     32'(gnt),          x ? 32'(1 << m_owner) : 32'd0);
    chk("wr_en",   32'(fifo_wr_en),   32'(x));
    chk("wr_data", 32'(fifo_wr_data), x ? 32'(pdata[m_owner]) : 32'd0);
    chk("owner",   32'(owner),        32'(m_owner));
    chk("busy",    32'(busy),         32'(m_burst));
    if (rst_n) trace.push_back({owner, gnt, fifo_wr_data});
  end

  // One cycle: note grants at the negedge, advance granted producers' data.
  task automatic step();
    logic [NREQ-1:0] gs;
    @(negedge clk);
    gs = gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (gs[i]) pdata[i] = pdata[i] + 8'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic e_idle(input int o);
    expq.push_back({2'(o), 4'b0000, 8'h00});
  endtask

  task automatic e_beat(input int o, input logic [7:0] d);
    expq.push_back({2'(o), 4'(1 << o), d});
  endtask

  task automatic begin_scn();
    trace.delete();
    expq.delete();
  endtask

  task automatic check_trace(input string name);
    chk({name, "_len"}, 32'(trace.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < trace.size(); i++)
      chk($sformatf("%s_cyc%0d", name, i), 32'(trace[i]), 32'(expq[i]));
  endtask

  initial begin
    clr = 1'b0; fifo_full = 1'b0; req = '0;
    for (int i = 0; i < NREQ; i++) pdata[i] = 8'h00;
    #1 rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Single requester: bubble, 4 beats, bubble, regrant, then drop
    pdata[0] = 8'h10;
    begin_scn();
    req = 4'b0001;
    run(7);
    req = 4'b0000;
    run(2);
    e_idle(0);
    for (int j = 0; j < 4; j++) e_beat(0, 8'(8'h10 + j));
    e_idle(0); e_beat(0, 8'h14); e_idle(0); e_idle(0);
    check_trace("solo");

    // clr in IDLE resets the pointer so producer 0 leads the rotation
    clr = 1'b1;
    step();
    clr = 1'b0;
    pdata[0] = 8'h20; pdata[1] = 8'h30; pdata[2] = 8'h40; pdata[3] = 8'h50;
    begin_scn();
    req = 4'b1111;
    run(25);
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      logic [7:0] base [5] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h24};
      int prev = 0;
      for (int b = 0; b < 5; b++) begin
        e_idle(prev);
        for (int j = 0; j < 4; j++) e_beat(order[b], 8'(base[b] + 8'(j)));
        prev = order[b];
      end
    end
    check_trace("rr4");

    // Full stall after first beat of owner 2
    begin_scn();
    req = 4'b0100;
    run(2);
    fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(3);
    e_idle(0); e_beat(2, 8'h44);
    for (int j = 0; j < 5; j++) e_idle(2);
    e_beat(2, 8'h45); e_beat(2, 8'h46); e_beat(2, 8'h47);
    check_trace("full");

    // Owner 1 drops request after 2 beats; producer 3 takes over
    begin_scn();
    req = 4'b0010;
    step();
    req = 4'b1010;
    run(2);
    req = 4'b1000;
    run(3);
    e_idle(2); e_beat(1, 8'h34); e_beat(1, 8'h35); e_idle(1); e_idle(1); e_beat(3, 8'h54);
    check_trace("drop");

    // clr mid-burst of owner 3, then 0 wins with req=1001
    begin_scn();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    req = 4'b1001;
    run(2);
    e_beat(3, 8'h55); e_idle(3); e_idle(3); e_beat(0, 8'h28);
    check_trace("clr");

    // Async reset mid-burst of owner 0
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),          32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en),   32'd0);
    chk("rst_data",  32'(fifo_wr_data), 32'd0);
    chk("rst_owner", 32'(owner),        32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    req = 4'b0110;
    run(2);
    rst_n = 1'b1;
    begin_scn();
    run(2);
    e_idle(0); e_beat(1, 8'h36);
    check_trace("post_rst");
    chk("p0_kept", 32'(pdata[0]), 32'h29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
